// File: rtl/scan_pkg.sv
// Shared types and helpers for the residual scan controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package scan_pkg;

  // Window row tag width, matching the residual compute w_row input.
  localparam int ROW_W = 5;

  // Scan controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

  // POI pixel address width: row bits plus column bits.
  function automatic int poi_addr_w(input int depth, input int width);
    return depth + width;
  endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Row/POI address counters for one scan; addr is the inner loop, row the outer.
// Latency: counters move on the edge after adv; last is combinational from the counters.
// Backpressure: counters hold whenever adv is low.
module scan_addr_gen
  import scan_pkg::*;
#(
  parameter int POI_ADDR_W = 8,
  parameter int W_ROWS     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  adv,
  output logic [POI_ADDR_W-1:0] addr,
  output logic [ROW_W-1:0]      row,
  output logic                  last
);

  logic [POI_ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  addr_max;

  assign addr = addr_q;
  assign row  = row_q;

  // Next counter values: addr wraps max->0 and carries into row; row wraps after the last one.
  always_comb begin
    addr_max = &addr_q;
    last     = addr_max && (row_q == ROW_W'(W_ROWS - 1));
    addr_d   = addr_q;
    row_d    = row_q;
    if (clr) begin
      addr_d = '0;
      row_d  = '0;
    end else if (adv) begin
      addr_d = addr_q + POI_ADDR_W'(1);
      if (addr_max) begin
        row_d = last ? '0 : row_q + ROW_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      row_q  <= '0;
    end else begin
      addr_q <= addr_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/residual_scan_ctrl.sv
// Sequences BRAM read -> residual compute -> residual write over every window row x POI pixel.
// Latency: start sampled at edge k, first read in cycle k+1, first res_wr_valid in cycle k+3.
// Backpressure: res_ready low with a residual pending freezes reads, compute and tags in place.
module residual_scan_ctrl
  import scan_pkg::*;
#(
  parameter int POI_DEPTH = 4,
  parameter int POI_WIDTH = 4,
  parameter int W_ROWS    = 32,
  localparam int POI_ADDR_W = poi_addr_w(POI_DEPTH, POI_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  poi_rd_en,
  output logic [POI_ADDR_W-1:0] poi_rd_addr,
  output logic                  win_rd_en,
  output logic [ROW_W-1:0]      win_rd_row,
  output logic                  compute_en,
  output logic [ROW_W-1:0]      compute_w_row,
  output logic [POI_ADDR_W-1:0] compute_poi,
  output logic                  res_wr_valid,
  input  logic                  res_ready
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
  localparam logic [1:0] ST_DONE  = 2'(DONE);

  logic [1:0]            state_q, state_d;
  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic [ROW_W-1:0]      tag_row_q, tag_row_d;
  logic [POI_ADDR_W-1:0] tag_poi_q, tag_poi_d;

  logic                  stall;
  logic                  rd_en;
  logic                  last;
  logic [POI_ADDR_W-1:0] addr;
  logic [ROW_W-1:0]      row;

  // A residual that cannot leave blocks every stage behind it; BRAM outputs hold since rd_en drops.
  assign stall = v2_q && !res_ready;
  assign rd_en = (state_q == ST_RUN) && !stall;

  scan_addr_gen #(
    .POI_ADDR_W (POI_ADDR_W),
    .W_ROWS     (W_ROWS)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (abort),
    .adv   (rd_en),
    .addr  (addr),
    .row   (row),
    .last  (last)
  );

  assign poi_rd_en     = rd_en;
  assign win_rd_en     = rd_en;
  assign poi_rd_addr   = addr;
  assign win_rd_row    = row;
  assign compute_en    = v1_q && !stall;
  assign compute_w_row = tag_row_q;
  assign compute_poi   = tag_poi_q;
  assign res_wr_valid  = v2_q;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);

  // Valid pipeline, tag capture and FSM; DRAIN exits on the cycle the pipe empties so done follows the last write.
  always_comb begin
    state_d   = state_q;
    v1_d      = stall ? v1_q : rd_en;
    v2_d      = stall ? v2_q : v1_q;
    tag_row_d = rd_en ? row  : tag_row_q;
    tag_poi_d = rd_en ? addr : tag_poi_q;
    case (state_q)
      ST_IDLE:  if (start)          state_d = ST_RUN;
      ST_RUN:   if (rd_en && last)  state_d = ST_DRAIN;
      ST_DRAIN: if (!v1_d && !v2_d) state_d = ST_DONE;
      default:                      state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      v1_d      = 1'b0;
      v2_d      = 1'b0;
      tag_row_d = '0;
      tag_poi_d = '0;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      tag_row_q <= '0;
      tag_poi_q <= '0;
    end else begin
      state_q   <= state_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      tag_row_q <= tag_row_d;
      tag_poi_q <= tag_poi_d;
    end
  end

endmodule

// File: tb/tb_residual_scan_ctrl.sv
// Bench for residual_scan_ctrl: small instance (2 rows x 4 pixels) plus a default-size instance.
// A downstream model captures compute tags and logs reads, valids, transfers, busy and done.
// Expected sequences come from op index i: row = i / pixels, addr = i % pixels.
module tb_residual_scan_ctrl;
  import scan_pkg::*;

  localparam int S_AW = 2;
  localparam int S_NP = 1 << S_AW;
  localparam int S_N  = 2 * S_NP;
  localparam int B_AW = 8;
  localparam int B_NP = 1 << B_AW;
  localparam int B_N  = 32 * B_NP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0, start = 1'b0, abort = 1'b0, res_ready = 1'b0;
  logic busy, done, poi_rd_en, win_rd_en, compute_en, res_wr_valid;
  logic [S_AW-1:0]  poi_rd_addr, compute_poi;
  logic [ROW_W-1:0] win_rd_row, compute_w_row;

  logic b_start = 1'b0, b_abort = 1'b0, b_res_ready = 1'b0;
  logic b_busy, b_done, b_poi_rd_en, b_win_rd_en, b_compute_en, b_res_wr_valid;
  logic [B_AW-1:0]  b_poi_rd_addr, b_compute_poi;
  logic [ROW_W-1:0] b_win_rd_row, b_compute_w_row;

  residual_scan_ctrl #(.POI_DEPTH(1), .POI_WIDTH(1), .W_ROWS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .poi_rd_en(poi_rd_en), .poi_rd_addr(poi_rd_addr), .win_rd_en(win_rd_en), .win_rd_row(win_rd_row),
    .compute_en(compute_en), .compute_w_row(compute_w_row), .compute_poi(compute_poi),
    .res_wr_valid(res_wr_valid), .res_ready(res_ready)
  );

  residual_scan_ctrl dut_big (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
    .poi_rd_en(b_poi_rd_en), .poi_rd_addr(b_poi_rd_addr), .win_rd_en(b_win_rd_en), .win_rd_row(b_win_rd_row),
    .compute_en(b_compute_en), .compute_w_row(b_compute_w_row), .compute_poi(b_compute_poi),
    .res_wr_valid(b_res_wr_valid), .res_ready(b_res_ready)
  );

  typedef struct {int cyc; int row; int poi;} ev_t;
  ev_t rd_log[$];
  ev_t xf_log[$];
  int  val_log[$];
  int  busy_log[$];
  int  done_log[$];
  int  en_mis = 0;
  int  cyc = 0;
  int  res_row = 0, res_poi = 0;
  int  checks = 0, errors = 0;

  // Edge counter; a sample taken in the period after edge n belongs to spec cycle n+1.
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream model and event logger for the small instance.
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      res_row = 0;
      res_poi = 0;
    end else begin
      if (poi_rd_en) begin
        e.cyc = cyc + 1; e.row = int'(win_rd_row); e.poi = int'(poi_rd_addr);
        rd_log.push_back(e);
      end
      if (poi_rd_en !== win_rd_en) en_mis++;
      if (res_wr_valid) val_log.push_back(cyc + 1);
      if (res_wr_valid && res_ready) begin
        e.cyc = cyc + 1; e.row = res_row; e.poi = res_poi;
        xf_log.push_back(e);
      end
      if (busy) busy_log.push_back(cyc + 1);
      if (done) done_log.push_back(cyc + 1);
      if (compute_en) begin
        res_row = int'(compute_w_row);
        res_poi = int'(compute_poi);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_log.delete(); xf_log.delete(); val_log.delete();
    busy_log.delete(); done_log.delete(); en_mis = 0;
  endtask

  task automatic start_scan(output int k);
    start = 1'b1;
    tick();
    k = cyc;
    start = 1'b0;
  endtask

  // mode 0: ready held high, 1: toggles each cycle, 2: random (high 3/4 of the time).
  task automatic wait_done(input int max_cyc, input int mode);
    int n0 = done_log.size();
    for (int i = 0; i < max_cyc; i++) begin
      if (done_log.size() != n0) break;
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ~res_ready;
        default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
      tick();
    end
    res_ready = 1'b1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, poi_rd_en, win_rd_en, compute_en, res_wr_valid, poi_rd_addr, win_rd_row,
         compute_w_row, compute_poi} !== '0)
      begin errors++; $display("FAIL reset_async_outputs got %h required 0", {busy, done, poi_rd_en,
        win_rd_en, compute_en, res_wr_valid, poi_rd_addr, win_rd_row, compute_w_row, compute_poi}); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({b_busy, b_done, b_poi_rd_en, b_win_rd_en, b_compute_en, b_res_wr_valid, b_poi_rd_addr,
         b_win_rd_row, b_compute_w_row, b_compute_poi} !== '0)
      begin errors++; $display("FAIL reset_big_outputs got %h required 0", {b_busy, b_done, b_poi_rd_en,
        b_win_rd_en, b_compute_en, b_res_wr_valid, b_poi_rd_addr, b_win_rd_row, b_compute_w_row, b_compute_poi}); end
    @(negedge clk) reset = 1'b0;
    tick();
    checks++;
    if ({busy, poi_rd_en, res_wr_valid} !== 3'b000)
      begin errors++; $display("FAIL reset_idle_after_release got %b required 000", {busy, poi_rd_en, res_wr_valid}); end
  endtask

  task automatic test_basic();
    int k;
    clear_logs();
    res_ready = 1'b1;
    start_scan(k);
    wait_done(40, 0);
    tick();
    checks++;
    if (rd_log.size() != S_N) begin errors++; $display("FAIL basic_rd_count got %0d required %0d", rd_log.size(), S_N); end
    for (int i = 0; i < rd_log.size() && i < S_N; i++) begin
      checks++;
      if (rd_log[i].cyc != k + 1 + i || rd_log[i].row != i / S_NP || rd_log[i].poi != i % S_NP) begin
        errors++;
        $display("FAIL basic_rd[%0d] got cyc %0d (%0d,%0d) required cyc %0d (%0d,%0d)", i,
                 rd_log[i].cyc - k, rd_log[i].row, rd_log[i].poi, 1 + i, i / S_NP, i % S_NP);
      end
    end
    checks++;
    if (xf_log.size() != S_N) begin errors++; $display("FAIL basic_xfer_count got %0d required %0d", xf_log.size(), S_N); end
    for (int i = 0; i < xf_log.size() && i < S_N; i++) begin
      checks++;
      if (xf_log[i].cyc != k + 3 + i || xf_log[i].row != i / S_NP || xf_log[i].poi != i % S_NP) begin
        errors++;
        $display("FAIL basic_xfer[%0d] got cyc %0d (%0d,%0d) required cyc %0d (%0d,%0d)", i,
                 xf_log[i].cyc - k, xf_log[i].row, xf_log[i].poi, 3 + i, i / S_NP, i % S_NP);
      end
    end
    checks++;
    if (val_log.size() != S_N || val_log[0] != k + 3 || val_log[val_log.size()-1] != k + S_N + 2)
      begin errors++; $display("FAIL basic_valid_window got %0d cycles required %0d from k+3", val_log.size(), S_N); end
    checks++;
    if (done_log.size() != 1 || done_log[0] != k + S_N + 3)
      begin errors++; $display("FAIL basic_done got %0d pulses first k+%0d required 1 at k+%0d",
        done_log.size(), done_log.size() ? done_log[0] - k : -1, S_N + 3); end
    checks++;
    if (busy_log.size() != S_N + 2 || busy_log[0] != k + 1 || busy_log[busy_log.size()-1] != k + S_N + 2)
      begin errors++; $display("FAIL basic_busy got %0d cycles required %0d (k+1..k+%0d)", busy_log.size(), S_N + 2, S_N + 2); end
    checks++;
    if (en_mis != 0) begin errors++; $display("FAIL basic_rd_en_match got %0d mismatches required 0", en_mis); end
  endtask

  task automatic test_stall();
    int k;
    logic [ROW_W-1:0] snap_row;
    logic [S_AW-1:0]  snap_poi;
    clear_logs();
    res_ready = 1'b1;
    start_scan(k);
    for (int i = 0; i < 20 && res_wr_valid !== 1'b1; i++) tick();
    tick();
    res_ready = 1'b0;
    #1;
    snap_row = compute_w_row;
    snap_poi = compute_poi;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      checks++;
      if ({poi_rd_en, win_rd_en, compute_en, res_wr_valid} !== 4'b0001)
        begin errors++; $display("FAIL stall_enables[%0d] got %b required 0001", c, {poi_rd_en, win_rd_en, compute_en, res_wr_valid}); end
      checks++;
      if (compute_w_row !== snap_row || compute_poi !== snap_poi)
        begin errors++; $display("FAIL stall_tags[%0d] got (%0d,%0d) required (%0d,%0d)", c, compute_w_row, compute_poi, snap_row, snap_poi); end
    end
    tick();
    wait_done(60, 0);
    tick();
    checks++;
    if (xf_log.size() != S_N) begin errors++; $display("FAIL stall_xfer_count got %0d required %0d", xf_log.size(), S_N); end
    for (int i = 0; i < xf_log.size() && i < S_N; i++) begin
      checks++;
      if (xf_log[i].row != i / S_NP || xf_log[i].poi != i % S_NP)
        begin errors++; $display("FAIL stall_xfer[%0d] got (%0d,%0d) required (%0d,%0d)", i, xf_log[i].row, xf_log[i].poi, i / S_NP, i % S_NP); end
    end
  endtask

  task automatic test_toggle();
    int k;
    clear_logs();
    res_ready = 1'b1;
    start_scan(k);
    wait_done(80, 1);
    tick();
    checks++;
    if (xf_log.size() != S_N) begin errors++; $display("FAIL toggle_xfer_count got %0d required %0d", xf_log.size(), S_N); end
    for (int i = 0; i < xf_log.size() && i < S_N; i++) begin
      checks++;
      if (xf_log[i].row != i / S_NP || xf_log[i].poi != i % S_NP)
        begin errors++; $display("FAIL toggle_xfer[%0d] got (%0d,%0d) required (%0d,%0d)", i, xf_log[i].row, xf_log[i].poi, i / S_NP, i % S_NP); end
    end
    checks++;
    if (done_log.size() != 1 || xf_log.size() == 0 || done_log[0] != xf_log[xf_log.size()-1].cyc + 1)
      begin errors++; $display("FAIL toggle_done got %0d pulses required 1 one cycle after last transfer", done_log.size()); end
  endtask

  task automatic test_back_to_back();
    int k;
    clear_logs();
    for (int s = 0; s < 3; s++) begin
      start_scan(k);
      wait_done(120, 2);
    end
    tick();
    checks++;
    if (xf_log.size() != 3 * S_N) begin errors++; $display("FAIL b2b_xfer_count got %0d required %0d", xf_log.size(), 3 * S_N); end
    for (int i = 0; i < xf_log.size() && i < 3 * S_N; i++) begin
      checks++;
      if (xf_log[i].row != (i % S_N) / S_NP || xf_log[i].poi != i % S_NP)
        begin errors++; $display("FAIL b2b_xfer[%0d] got (%0d,%0d) required (%0d,%0d)", i, xf_log[i].row, xf_log[i].poi, (i % S_N) / S_NP, i % S_NP); end
    end
    checks++;
    if (done_log.size() != 3) begin errors++; $display("FAIL b2b_done_count got %0d required 3", done_log.size()); end
  endtask

  task automatic test_abort();
    int k;
    clear_logs();
    res_ready = 1'b1;
    start_scan(k);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, poi_rd_en, compute_en, res_wr_valid, poi_rd_addr, win_rd_row} !== '0)
      begin errors++; $display("FAIL abort_idle got %h required 0", {busy, poi_rd_en, compute_en, res_wr_valid, poi_rd_addr, win_rd_row}); end
    repeat (5) tick();
    checks++;
    if (done_log.size() != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses required 0", done_log.size()); end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_wins_over_start got busy %b required 0", busy); end
    clear_logs();
    start_scan(k);
    wait_done(40, 0);
    tick();
    checks++;
    if (rd_log.size() != S_N || rd_log[0].row != 0 || rd_log[0].poi != 0 || rd_log[0].cyc != k + 1)
      begin errors++; $display("FAIL abort_restart_reads got %0d reads required %0d from (0,0) at k+1", rd_log.size(), S_N); end
    checks++;
    if (xf_log.size() != S_N || done_log.size() != 1)
      begin errors++; $display("FAIL abort_restart_scan got %0d transfers %0d done required %0d and 1", xf_log.size(), done_log.size(), S_N); end
  endtask

  task automatic test_async_reset();
    int k;
    clear_logs();
    res_ready = 1'b1;
    start_scan(k);
    repeat (5) tick();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, poi_rd_en, win_rd_en, compute_en, res_wr_valid, poi_rd_addr, win_rd_row,
         compute_w_row, compute_poi} !== '0)
      begin errors++; $display("FAIL areset_immediate got %h required 0", {busy, done, poi_rd_en,
        win_rd_en, compute_en, res_wr_valid, poi_rd_addr, win_rd_row, compute_w_row, compute_poi}); end
    tick();
    #2 reset = 1'b0;
    tick();
    checks++;
    if ({busy, poi_rd_en, res_wr_valid} !== 3'b000)
      begin errors++; $display("FAIL areset_stays_idle got %b required 000", {busy, poi_rd_en, res_wr_valid}); end
    clear_logs();
    start_scan(k);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(40, 0);
    repeat (4) tick();
    checks++;
    if (xf_log.size() != S_N || rd_log.size() != S_N)
      begin errors++; $display("FAIL start_while_busy got %0d reads %0d transfers required %0d", rd_log.size(), xf_log.size(), S_N); end
    checks++;
    if (done_log.size() != 1) begin errors++; $display("FAIL start_while_busy_done got %0d pulses required 1", done_log.size()); end
  endtask

  task automatic test_default_size();
    int k, n_rd = 0, n_xf = 0, mism = 0, done_cyc = -1;
    b_res_ready = 1'b1;
    b_start = 1'b1;
    tick();
    k = cyc;
    b_start = 1'b0;
    for (int i = 0; i < B_N + 200 && done_cyc < 0; i++) begin
      if (b_poi_rd_en) begin
        if (int'(b_win_rd_row) != n_rd / B_NP || int'(b_poi_rd_addr) != n_rd % B_NP) mism++;
        n_rd++;
      end
      if (b_res_wr_valid && b_res_ready) n_xf++;
      if (b_done) done_cyc = cyc + 1;
      tick();
    end
    checks++;
    if (n_rd != B_N || mism != 0) begin errors++; $display("FAIL default_reads got %0d (%0d out of order) required %0d", n_rd, mism, B_N); end
    checks++;
    if (n_xf != B_N) begin errors++; $display("FAIL default_xfers got %0d required %0d", n_xf, B_N); end
    checks++;
    if (done_cyc != k + B_N + 3) begin errors++; $display("FAIL default_done got k+%0d required k+%0d", done_cyc - k, B_N + 3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_toggle();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_default_size();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
